axi_slave_mem: RTL and testbench
================================

AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data bus width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32: address width in bits.
REQ-003 SHALL have parameter ID_W, default 4: transaction ID width in bits.
REQ-004 SHALL have parameter DEPTH, default 256: storage size in DATA_W-bit words; must be a power of 2.
REQ-005 SHALL have port ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port ASW_RESET, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have ports AWVALID (input, 1) and AWREADY (output, 1): write-address handshake.
REQ-008 SHALL have ports AWADDR (input, ADDR_W), AWLEN (input, 4), AWBURST (input, 2) and AWID (input, ID_W): write-address payload.
REQ-009 SHALL have ports WVALID (input, 1), WREADY (output, 1) and WLAST (input, 1): write-data handshake and last-beat flag.
REQ-010 SHALL have ports WDATA (input, DATA_W) and WSTRB (input, DATA_W/8): write data and byte enables.
REQ-011 SHALL have ports BVALID (output, 1), BREADY (input, 1), BRESP (output, 2) and BID (output, ID_W): write-response channel.
REQ-012 SHALL have ports ARVALID (input, 1), ARREADY (output, 1), ARADDR (input, ADDR_W), ARLEN (input, 4), ARBURST (input, 2) and ARID (input, ID_W): read-address channel.
REQ-013 SHALL have ports RVALID (output, 1), RREADY (input, 1), RDATA (output, DATA_W), RRESP (output, 2), RID (output, ID_W) and RLAST (output, 1): read-data channel.

Function
REQ-014 SHALL compute the word index as address[ADDR_W-1 : log2(DATA_W/8)]; an index >= DEPTH is out of range.
REQ-015 SHALL advance the address per beat as follows: INCR (01) adds DATA_W/8; FIXED (00) holds it; WRAP (10) and 11 are unsupported bursts.
REQ-016 SHALL run the write FSM through W_IDLE (AWREADY=1), W_DATA (WREADY=1) and W_RESP (BVALID=1); the AW handshake captures AWADDR, AWLEN, AWBURST and AWID and moves to W_DATA on the next cycle.
REQ-017 SHALL write each W beat as follows: on WVALID&WREADY, write the bytes enabled by WSTRB; skip the write if the index is out of range, the burst is unsupported, or the beat count exceeds AWLEN+1.
REQ-018 SHALL leave W_DATA only on the WLAST beat, then go to W_RESP; BID equals the captured AWID.
REQ-019 SHALL set BRESP=SLVERR (10) if any beat was out of range, the burst was unsupported, or the beat count at WLAST differs from AWLEN+1; otherwise BRESP=OKAY (00).
REQ-020 SHALL hold BVALID, BRESP and BID stable until BREADY; after the B handshake the FSM returns to W_IDLE, with AWREADY high on the following cycle.
REQ-021 SHALL run the read FSM through R_IDLE (ARREADY=1) and R_DATA (RVALID=1); the AR handshake captures ARADDR, ARLEN, ARBURST and ARID.
REQ-022 SHALL present the first beat's RDATA with RVALID on the cycle after the AR handshake (latency 1).
REQ-023 SHALL keep RDATA, RRESP, RID and RLAST stable while RVALID&!RREADY.
REQ-024 SHALL present the next beat on the cycle after each R handshake, with no bubbles while RREADY is held high.
REQ-025 SHALL assert RLAST on beat number ARLEN (counting from 0); the R_DATA to R_IDLE transition occurs on the RLAST handshake.
REQ-026 SHALL return RDATA=0 and RRESP=SLVERR on a read beat that is out of range or part of an unsupported burst; all other beats return RRESP=OKAY.
REQ-027 SHALL keep the read and write FSMs independent; both channels may be active in the same cycle.
REQ-028 SHALL give a read that samples the same word as a same-cycle write the pre-write contents (write-first is not allowed).
REQ-029 SHALL accept ARLEN=0 and AWLEN=0 as single-beat bursts.
REQ-030 SHALL pass a burst whose INCR addresses run past DEPTH through the in-range beats normally and flag SLVERR on each out-of-range beat.

Reset
REQ-031 SHALL, while ASW_RESET=1, force AWREADY, WREADY, BVALID, ARREADY, RVALID and RLAST to 0, and BRESP, BID, RDATA, RRESP and RID to 0.
REQ-032 SHALL, on ASW_RESET deassertion, place both FSMs in IDLE, with AWREADY=1 and ARREADY=1 on the first edge after release.
REQ-033 SHALL, on reset in mid-burst, abandon any in-flight burst with no B or R response issued; memory contents are not cleared.

Verification
REQ-034 SHALL pass this test: AW addr 0x10, INCR, AWLEN=3, ID 5, then 4 beats of 0xA0..0xA3 with WSTRB=F -> BRESP=00 and BID=5; AR of the same burst returns 0xA0..0xA3, with RLAST on the 4th beat.
REQ-035 SHALL pass this test: a write of 0xFFFFFFFF to 0x20, then a write of 0x12345678 with WSTRB=0011 -> a read of 0x20 returns 0xFFFF5678.
REQ-036 SHALL pass this test: FIXED burst at 0x40 with AWLEN=2 and data 1,2,3 -> a read of 0x40 returns 3.
REQ-037 SHALL pass this test: with DEPTH=256, an INCR read at 0x3F8 with ARLEN=3 -> beats 0 and 1 return OKAY, beats 2 and 3 return SLVERR with RDATA=0.
REQ-038 SHALL pass this test: WLAST on beat 2 with AWLEN=3 -> BRESP=SLVERR; and RREADY held low for 5 cycles -> RDATA stays stable and no beat is lost.
REQ-039 SHALL pass this test: ASW_RESET pulsed during beat 2 of an 8-beat read -> RVALID=0 immediately, ARREADY=1 after release, and a new read returns the previously written data.

Source files
------------

// File: rtl/axi_slave_mem.sv
// AXI4 slave with on-chip word memory: independent write (AW/W/B) and read (AR/R) FSMs,
// INCR and FIXED bursts, SLVERR on out-of-range words, unsupported bursts and bad write lengths.
module axi_slave_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 256
) (
  input  logic                ACLK,
  input  logic                ASW_RESET,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [3:0]          AWLEN,
  input  logic [1:0]          AWBURST,
  input  logic [ID_W-1:0]     AWID,
  input  logic                WVALID,
  output logic                WREADY,
  input  logic                WLAST,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  output logic                BVALID,
  input  logic                BREADY,
  output logic [1:0]          BRESP,
  output logic [ID_W-1:0]     BID,
  input  logic                ARVALID,
  output logic                ARREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [3:0]          ARLEN,
  input  logic [1:0]          ARBURST,
  input  logic [ID_W-1:0]     ARID,
  output logic                RVALID,
  input  logic                RREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic [ID_W-1:0]     RID,
  output logic                RLAST
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA} rstate_t;

  logic [DATA_W-1:0] r_mem [DEPTH];

  function automatic logic f_oob(input logic [ADDR_W-1:0] a);
    return (a >> LSB) >= ADDR_W'(DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_W-1:0] a);
    return a[LSB +: IDX_W];
  endfunction

  // WRAP and the reserved encoding never advance; their beats are errored anyway.
  function automatic logic [ADDR_W-1:0] f_next(input logic [ADDR_W-1:0] a, input logic [1:0] burst);
    return (burst == 2'b01) ? a + ADDR_W'(STRB_W) : a;
  endfunction

  // ---------------- write channel ----------------
  wstate_t           r_wstate;
  logic [ADDR_W-1:0] r_awaddr;
  logic [3:0]        r_awlen;
  logic [1:0]        r_awburst;
  logic [ID_W-1:0]   r_awid;
  logic [4:0]        r_wcnt;
  logic              r_werr;
  logic              r_awready;
  logic              r_wready;
  logic              r_bvalid;
  logic [1:0]        r_bresp;
  logic [ID_W-1:0]   r_bid;

  logic w_wbeat, w_woob, w_wburst_ok, w_wcnt_ok, w_wen, w_werr_next;

  assign w_wbeat     = r_wready & WVALID;
  assign w_woob      = f_oob(r_awaddr);
  assign w_wburst_ok = ~r_awburst[1];
  assign w_wcnt_ok   = r_wcnt <= {1'b0, r_awlen};
  assign w_wen       = w_wbeat & ~w_woob & w_wburst_ok & w_wcnt_ok;
  assign w_werr_next = r_werr | w_woob | ~w_wburst_ok;

  always_ff @(posedge ACLK or posedge ASW_RESET) begin
    if (ASW_RESET) begin
      r_wstate  <= W_IDLE;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_awburst <= '0;
      r_awid    <= '0;
      r_wcnt    <= '0;
      r_werr    <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= '0;
      r_bid     <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (r_awready && AWVALID) begin
            r_awaddr  <= AWADDR;
            r_awlen   <= AWLEN;
            r_awburst <= AWBURST;
            r_awid    <= AWID;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end else begin
            r_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_wbeat) begin
            r_awaddr <= f_next(r_awaddr, r_awburst);
            if (r_wcnt != 5'h1f) r_wcnt <= r_wcnt + 5'd1;
            r_werr <= w_werr_next;
            if (WLAST) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (w_werr_next || (r_wcnt != {1'b0, r_awlen})) ? 2'b10 : 2'b00;
              r_bid    <= r_awid;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Storage survives reset, so it lives in its own unreset block.
  always_ff @(posedge ACLK) begin
    if (w_wen) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) r_mem[f_idx(r_awaddr)][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  rstate_t           r_rstate;
  logic [ADDR_W-1:0] r_araddr;
  logic [3:0]        r_arlen;
  logic [1:0]        r_arburst;
  logic [3:0]        r_rcnt;
  logic              r_arready;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;
  logic [ID_W-1:0]   r_rid;
  logic              r_rlast;

  logic              w_arhs, w_rhs, w_rerr;
  logic [ADDR_W-1:0] w_raddr;
  logic [1:0]        w_rburst;
  logic [DATA_W-1:0] w_rword;

  assign w_arhs   = r_arready & ARVALID;
  assign w_rhs    = r_rvalid & RREADY;
  // r_araddr always holds the address of the beat to be loaded next
  assign w_raddr  = (r_rstate == R_IDLE) ? ARADDR : r_araddr;
  assign w_rburst = (r_rstate == R_IDLE) ? ARBURST : r_arburst;
  assign w_rerr   = f_oob(w_raddr) | w_rburst[1];
  assign w_rword  = r_mem[f_idx(w_raddr)];

  always_ff @(posedge ACLK or posedge ASW_RESET) begin
    if (ASW_RESET) begin
      r_rstate  <= R_IDLE;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arburst <= '0;
      r_rcnt    <= '0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= '0;
      r_rid     <= '0;
      r_rlast   <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_arhs) begin
            r_arlen   <= ARLEN;
            r_arburst <= ARBURST;
            r_rid     <= ARID;
            r_araddr  <= f_next(ARADDR, ARBURST);
            r_rcnt    <= '0;
            r_rlast   <= (ARLEN == 4'd0);
            r_rdata   <= w_rerr ? '0 : w_rword;
            r_rresp   <= w_rerr ? 2'b10 : 2'b00;
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
            r_rstate  <= R_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (w_rhs) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_araddr <= f_next(r_araddr, r_arburst);
              r_rcnt   <= r_rcnt + 4'd1;
              r_rlast  <= ((r_rcnt + 4'd1) == r_arlen);
              r_rdata  <= w_rerr ? '0 : w_rword;
              r_rresp  <= w_rerr ? 2'b10 : 2'b00;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign AWREADY = r_awready;
  assign WREADY  = r_wready;
  assign BVALID  = r_bvalid;
  assign BRESP   = r_bresp;
  assign BID     = r_bid;
  assign ARREADY = r_arready;
  assign RVALID  = r_rvalid;
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;
  assign RID     = r_rid;
  assign RLAST   = r_rlast;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed self-checking bench for axi_slave_mem (DATA_W=32, DEPTH=256).
module tb_axi_slave_mem;
  logic        ACLK, ASW_RESET;
  logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]  AWLEN, ARLEN, AWID, ARID, BID, RID, WSTRB;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;

  axi_slave_mem #(.DATA_W(32), .ADDR_W(32), .ID_W(4), .DEPTH(256)) dut (
    .ACLK(ACLK), .ASW_RESET(ASW_RESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST), .AWID(AWID),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST), .ARID(ARID),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RID(RID), .RLAST(RLAST)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int tests, fails;
  logic [31:0] wdat [16];
  logic [3:0]  wstb [16];
  logic [31:0] rdat [16];
  logic [1:0]  rrsp [16];
  logic        rlst [16];
  logic [3:0]  rids [16];
  int rbeats, rlat, rgaps;
  logic [1:0] bresp_g;
  logic [3:0] bid_g;
  bit ok;

  task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                          input logic [3:0] id, input int nbeats,
                          output logic [1:0] bresp, output logic [3:0] bid, output bit wok);
    int t;
    wok = 1;
    @(negedge ACLK);
    AWADDR = addr; AWLEN = len; AWBURST = burst; AWID = id; AWVALID = 1;
    t = 0;
    while (!AWREADY && t < 50) begin @(negedge ACLK); t++; end
    if (t >= 50) wok = 0;
    @(negedge ACLK);
    AWVALID = 0;
    for (int b = 0; b < nbeats; b++) begin
      WDATA = wdat[b]; WSTRB = wstb[b]; WLAST = (b == nbeats - 1); WVALID = 1;
      t = 0;
      while (!WREADY && t < 50) begin @(negedge ACLK); t++; end
      if (t >= 50) wok = 0;
      @(negedge ACLK);
    end
    WVALID = 0; WLAST = 0; BREADY = 1;
    t = 0;
    while (!BVALID && t < 50) begin @(negedge ACLK); t++; end
    if (t >= 50) wok = 0;
    bresp = BRESP; bid = BID;
    @(negedge ACLK);
    BREADY = 0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                         input logic [3:0] id, output bit rok);
    int t;
    bit done;
    rok = 1;
    @(negedge ACLK);
    ARADDR = addr; ARLEN = len; ARBURST = burst; ARID = id; ARVALID = 1; RREADY = 1;
    t = 0;
    while (!ARREADY && t < 50) begin @(negedge ACLK); t++; end
    if (t >= 50) rok = 0;
    @(negedge ACLK);
    ARVALID = 0;
    rlat = 0;
    while (!RVALID && rlat < 50) begin @(negedge ACLK); rlat++; end
    rbeats = 0; rgaps = 0; t = 0; done = 0;
    while (!done && rbeats < 16 && t < 100) begin
      if (RVALID) begin
        rdat[rbeats] = RDATA; rrsp[rbeats] = RRESP; rlst[rbeats] = RLAST; rids[rbeats] = RID;
        rbeats++;
        if (RLAST) done = 1;
      end else begin
        rgaps++;
      end
      @(negedge ACLK);
      t++;
    end
    if (!done) rok = 0;
    RREADY = 0;
  endtask

  task automatic fill1(input logic [31:0] addr, input logic [31:0] d);
    wdat[0] = d; wstb[0] = 4'hF;
    do_write(addr, 4'd0, 2'b01, 4'd0, 1, bresp_g, bid_g, ok);
  endtask

  task automatic test_reset();
    ASW_RESET = 1;
    repeat (3) @(negedge ACLK);
    tests++;
    if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl got=%b exp=000000", {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST});
    end
    tests++;
    if ({BRESP, BID, RDATA, RRESP, RID} !== 44'h0) begin
      fails++; $display("FAIL reset_data got=%h exp=0", {BRESP, BID, RDATA, RRESP, RID});
    end
    ASW_RESET = 0;
    @(posedge ACLK); #1;
    tests++;
    if ({AWREADY, ARREADY} !== 2'b11) begin
      fails++; $display("FAIL reset_release_ready got=%b exp=11", {AWREADY, ARREADY});
    end
  endtask

  task automatic test_incr_burst();
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'hA0 + i; wstb[i] = 4'hF; end
    do_write(32'h10, 4'd3, 2'b01, 4'd5, 4, bresp_g, bid_g, ok);
    tests++;
    if (!ok || bresp_g !== 2'b00 || bid_g !== 4'd5) begin
      fails++; $display("FAIL incr_wr_b ok=%0d got resp=%b id=%0d exp resp=00 id=5", ok, bresp_g, bid_g);
    end
    do_read(32'h10, 4'd3, 2'b01, 4'd7, ok);
    tests++;
    if (!ok || rbeats != 4 || rlat != 0 || rgaps != 0) begin
      fails++; $display("FAIL incr_rd_shape ok=%0d beats=%0d lat=%0d gaps=%0d exp 1/4/0/0", ok, rbeats, rlat, rgaps);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rdat[i] !== 32'hA0 + i || rrsp[i] !== 2'b00 || rlst[i] !== (i == 3) || rids[i] !== 4'd7) begin
        fails++; $display("FAIL incr_rd_beat%0d got data=%h resp=%b last=%b id=%0d exp data=%h resp=00 last=%0d id=7",
                          i, rdat[i], rrsp[i], rlst[i], rids[i], 32'hA0 + i, (i == 3));
      end
    end
  endtask

  task automatic test_strobe();
    fill1(32'h20, 32'hFFFF_FFFF);
    wdat[0] = 32'h1234_5678; wstb[0] = 4'b0011;
    do_write(32'h20, 4'd0, 2'b01, 4'd0, 1, bresp_g, bid_g, ok);
    do_read(32'h20, 4'd0, 2'b01, 4'd0, ok);
    tests++;
    if (!ok || rdat[0] !== 32'hFFFF_5678 || rlst[0] !== 1'b1) begin
      fails++; $display("FAIL strobe got=%h last=%b exp=ffff5678 last=1", rdat[0], rlst[0]);
    end
  endtask

  task automatic test_fixed();
    for (int i = 0; i < 3; i++) begin wdat[i] = i + 1; wstb[i] = 4'hF; end
    do_write(32'h40, 4'd2, 2'b00, 4'd2, 3, bresp_g, bid_g, ok);
    tests++;
    if (!ok || bresp_g !== 2'b00) begin
      fails++; $display("FAIL fixed_bresp got=%b exp=00", bresp_g);
    end
    do_read(32'h40, 4'd0, 2'b01, 4'd0, ok);
    tests++;
    if (rdat[0] !== 32'd3) begin
      fails++; $display("FAIL fixed_data got=%h exp=3", rdat[0]);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] exp_d [4];
    logic [1:0]  exp_r [4];
    wdat[0] = 32'hE0; wdat[1] = 32'hE1; wstb[0] = 4'hF; wstb[1] = 4'hF;
    do_write(32'h3F8, 4'd1, 2'b01, 4'd0, 2, bresp_g, bid_g, ok);
    exp_d[0] = 32'hE0; exp_d[1] = 32'hE1; exp_d[2] = 0; exp_d[3] = 0;
    exp_r[0] = 2'b00; exp_r[1] = 2'b00; exp_r[2] = 2'b10; exp_r[3] = 2'b10;
    do_read(32'h3F8, 4'd3, 2'b01, 4'd0, ok);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rdat[i] !== exp_d[i] || rrsp[i] !== exp_r[i] || rlst[i] !== (i == 3)) begin
        fails++; $display("FAIL oob_rd_beat%0d got data=%h resp=%b last=%b exp data=%h resp=%b",
                          i, rdat[i], rrsp[i], rlst[i], exp_d[i], exp_r[i]);
      end
    end
    fill1(32'h0, 32'h1111_1111);
    wdat[0] = 32'hD0; wdat[1] = 32'hDEAD;
    do_write(32'h3FC, 4'd1, 2'b01, 4'd0, 2, bresp_g, bid_g, ok);
    tests++;
    if (bresp_g !== 2'b10) begin
      fails++; $display("FAIL oob_wr_bresp got=%b exp=10", bresp_g);
    end
    do_read(32'h0, 4'd0, 2'b01, 4'd0, ok);
    tests++;
    if (rdat[0] !== 32'h1111_1111) begin
      fails++; $display("FAIL oob_wr_alias got=%h exp=11111111", rdat[0]);
    end
    do_read(32'h3FC, 4'd0, 2'b01, 4'd0, ok);
    tests++;
    if (rdat[0] !== 32'hD0) begin
      fails++; $display("FAIL oob_wr_inrange got=%h exp=d0", rdat[0]);
    end
  endtask

  task automatic test_errors();
    for (int i = 0; i < 2; i++) begin wdat[i] = 32'h60 + i; wstb[i] = 4'hF; end
    do_write(32'h60, 4'd3, 2'b01, 4'd3, 2, bresp_g, bid_g, ok);
    tests++;
    if (!ok || bresp_g !== 2'b10 || bid_g !== 4'd3) begin
      fails++; $display("FAIL early_wlast got resp=%b id=%0d exp resp=10 id=3", bresp_g, bid_g);
    end
    fill1(32'h300, 32'h77);
    wdat[0] = 32'h88; wdat[1] = 32'h99;
    do_write(32'h300, 4'd1, 2'b10, 4'd0, 2, bresp_g, bid_g, ok);
    tests++;
    if (bresp_g !== 2'b10) begin
      fails++; $display("FAIL wrap_wr_bresp got=%b exp=10", bresp_g);
    end
    do_read(32'h300, 4'd0, 2'b01, 4'd0, ok);
    tests++;
    if (rdat[0] !== 32'h77 || rrsp[0] !== 2'b00) begin
      fails++; $display("FAIL wrap_wr_nowrite got=%h resp=%b exp=77 resp=00", rdat[0], rrsp[0]);
    end
    do_read(32'h300, 4'd0, 2'b10, 4'd0, ok);
    tests++;
    if (rdat[0] !== 32'h0 || rrsp[0] !== 2'b10) begin
      fails++; $display("FAIL wrap_rd got=%h resp=%b exp=0 resp=10", rdat[0], rrsp[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got0;
    bit stable;
    int t;
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'hB0 + i; wstb[i] = 4'hF; end
    do_write(32'h80, 4'd3, 2'b01, 4'd0, 4, bresp_g, bid_g, ok);
    @(negedge ACLK);
    ARADDR = 32'h80; ARLEN = 4'd3; ARBURST = 2'b01; ARID = 4'd1; ARVALID = 1; RREADY = 0;
    t = 0;
    while (!ARREADY && t < 50) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    ARVALID = 0;
    got0 = RDATA;
    RREADY = 1;
    @(negedge ACLK);
    RREADY = 0;
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      if (!RVALID || RDATA !== 32'hB1 || RLAST !== 1'b0) stable = 0;
      @(negedge ACLK);
    end
    tests++;
    if (got0 !== 32'hB0 || !stable) begin
      fails++; $display("FAIL bp_stall got beat0=%h stable=%0d exp beat0=b0 stable=1", got0, stable);
    end
    RREADY = 1;
    for (int i = 1; i < 4; i++) begin
      tests++;
      if (!RVALID || RDATA !== 32'hB0 + i || RLAST !== (i == 3)) begin
        fails++; $display("FAIL bp_beat%0d got valid=%b data=%h last=%b exp valid=1 data=%h", i, RVALID, RDATA, RLAST, 32'hB0 + i);
      end
      @(negedge ACLK);
    end
    RREADY = 0;
    tests++;
    if (RVALID !== 1'b0) begin
      fails++; $display("FAIL bp_end got rvalid=%b exp=0", RVALID);
    end
  endtask

  task automatic test_reset_midburst();
    int t;
    for (int i = 0; i < 8; i++) begin wdat[i] = 32'hC0 + i; wstb[i] = 4'hF; end
    do_write(32'h100, 4'd7, 2'b01, 4'd0, 8, bresp_g, bid_g, ok);
    @(negedge ACLK);
    ARADDR = 32'h100; ARLEN = 4'd7; ARBURST = 2'b01; ARID = 4'd2; ARVALID = 1; RREADY = 1;
    t = 0;
    while (!ARREADY && t < 50) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    ARVALID = 0;
    repeat (2) @(negedge ACLK);
    ASW_RESET = 1; RREADY = 0;
    #1;
    tests++;
    if (RVALID !== 1'b0 || BVALID !== 1'b0) begin
      fails++; $display("FAIL midreset_rvalid got rvalid=%b bvalid=%b exp 0/0", RVALID, BVALID);
    end
    @(negedge ACLK);
    ASW_RESET = 0;
    @(posedge ACLK); #1;
    tests++;
    if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
      fails++; $display("FAIL midreset_release got arready=%b rvalid=%b exp 1/0", ARREADY, RVALID);
    end
    do_read(32'h100, 4'd7, 2'b01, 4'd0, ok);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (rdat[i] !== 32'hC0 + i || rlst[i] !== (i == 7)) begin
        fails++; $display("FAIL midreset_data%0d got=%h last=%b exp=%h", i, rdat[i], rlst[i], 32'hC0 + i);
      end
    end
  endtask

  task automatic test_same_cycle();
    int t;
    fill1(32'h200, 32'h55);
    @(negedge ACLK);
    AWADDR = 32'h200; AWLEN = 4'd0; AWBURST = 2'b01; AWID = 4'd1; AWVALID = 1;
    t = 0;
    while (!AWREADY && t < 50) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    AWVALID = 0;
    t = 0;
    while ((!WREADY || !ARREADY) && t < 50) begin @(negedge ACLK); t++; end
    tests++;
    if (t >= 50) begin
      fails++; $display("FAIL same_cycle_setup got wready=%b arready=%b exp 1/1", WREADY, ARREADY);
    end
    WDATA = 32'hAA; WSTRB = 4'hF; WLAST = 1; WVALID = 1;
    ARADDR = 32'h200; ARLEN = 4'd0; ARBURST = 2'b01; ARID = 4'd0; ARVALID = 1; RREADY = 1;
    @(negedge ACLK);
    WVALID = 0; WLAST = 0; ARVALID = 0;
    tests++;
    if (RVALID !== 1'b1 || RDATA !== 32'h55) begin
      fails++; $display("FAIL same_cycle_old got valid=%b data=%h exp valid=1 data=55", RVALID, RDATA);
    end
    BREADY = 1;
    t = 0;
    while (!BVALID && t < 50) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    BREADY = 0; RREADY = 0;
    do_read(32'h200, 4'd0, 2'b01, 4'd0, ok);
    tests++;
    if (rdat[0] !== 32'hAA) begin
      fails++; $display("FAIL same_cycle_new got=%h exp=aa", rdat[0]);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    ASW_RESET = 1;
    AWVALID = 0; AWADDR = 0; AWLEN = 0; AWBURST = 0; AWID = 0;
    WVALID = 0; WLAST = 0; WDATA = 0; WSTRB = 0; BREADY = 0;
    ARVALID = 0; ARADDR = 0; ARLEN = 0; ARBURST = 0; ARID = 0; RREADY = 0;
    test_reset();
    test_incr_burst();
    test_strobe();
    test_fixed();
    test_out_of_range();
    test_errors();
    test_backpressure();
    test_reset_midburst();
    test_same_cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
